foo_port_loader: RTL and testbench

Serial-to-parallel loader that assembles the complete input port bundle of `foo` (`y`, `x`, `abcconst`, `noconnect`, `def`) from a one-bit-per-cycle stream and presents it with a valid/ack handshake. It is the writer side of the `foo` port interface. It sits between the test/config serial link and any `foo` instance, so `foo` always sees a coherent, fully-updated bundle and never a partially shifted one.

---
 rtl/foo_loader_pkg.sv | 33 +++
 rtl/foo_loader_shreg.sv | 37 +++
 rtl/foo_port_loader.sv | 174 +++++++++++++++++
 tb/tb_foo_port_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/foo_loader_pkg.sv
// -----------------------------------------------------------------------------
// foo_loader_pkg
// Shared types and constants for the foo port-bundle serial loader.
//   state_t    : loader FSM states (IDLE, SHIFT, PARITY, HOLD)
//   *_W        : widths of the fixed bundle fields y, x, abcconst, noconnect
//   frame_len  : number of data bits in one frame for a given def width
//   cnt_width  : width of the bit counter, $clog2(frame_len + 1)
// Optional feature macro used by the loader: FOO_LOADER_PARITY_EN.
// -----------------------------------------------------------------------------
package foo_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam int Y_W   = 1;
   localparam int X_W   = 1;
   localparam int ABC_W = 3;
   localparam int NC_W  = 4;
   localparam int HDR_W = Y_W + X_W + ABC_W + NC_W;

   function automatic int frame_len(input int def_w);
      return HDR_W + def_w;
   endfunction

   function automatic int cnt_width(input int def_w);
      return $clog2(frame_len(def_w) + 1);
   endfunction

endpackage

// File: rtl/foo_loader_shreg.sv
// -----------------------------------------------------------------------------
// foo_loader_shreg
// LEN-bit left-shifting register (new bit enters at bit 0, so the first bit
// received ends up in the MSB) plus a running XOR of every bit shifted in.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear data and parity (frame start); wins over shift_en
//   shift_en   : shift sdi in this cycle
//   sdi        : serial data bit
//   data       : shift register contents
//   parity     : XOR of all bits shifted in since the last clear
// -----------------------------------------------------------------------------
module foo_loader_shreg #(
   parameter int LEN = 41
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           shift_en,
   input  logic           sdi,
   output logic [LEN-1:0] data,
   output logic           parity
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data   <= '0;
         parity <= 1'b0;
      end else if (clr) begin
         data   <= '0;
         parity <= 1'b0;
      end else if (shift_en) begin
         data   <= {data[LEN-2:0], sdi};
         parity <= parity ^ sdi;
      end
   end

endmodule

// File: rtl/foo_port_loader.sv
// -----------------------------------------------------------------------------
// foo_port_loader
// Serial-to-parallel writer for the foo input port bundle. Bits arrive one per
// sdi_valid cycle in field order y, x, abcconst, noconnect, def (each MSB
// first); the bundle outputs change only when a complete frame commits.
//
// Build option: define FOO_LOADER_PARITY_EN to add a trailing even-parity bit
// (PARITY state, live par_err). Without it the frame commits on the last data
// bit and par_err is constant 0.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_start            : pulse that opens (or restarts) a frame
//   sdi, sdi_valid        : serial data bit and its qualifier
//   y, x, abcconst,
//   noconnect, def        : committed bundle (noconnect is signed at consumer)
//   bundle_valid          : bundle holds a complete, unconsumed frame
//   bundle_ack            : consumer has taken the bundle
//   busy                  : frame in progress (SHIFT or PARITY)
//   overrun               : pulse, load_start refused while holding a bundle
//   par_err               : pulse, parity mismatch, frame discarded
//   state_dbg             : current FSM state
//
// Handshake: bundle_valid rises on the edge that commits a frame and stays high
// until an edge samples bundle_ack=1; the bundle is stable for that whole time.
// bundle_ack is only meaningful while bundle_valid=1. A load_start sampled
// together with bundle_ack in HOLD starts the next frame immediately.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module foo_port_loader
   import foo_loader_pkg::*;
#(
   parameter int DEF_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             sdi,
   input  logic             sdi_valid,
   output logic             y,
   output logic             x,
   output logic [ABC_W-1:0] abcconst,
   output logic [NC_W-1:0]  noconnect,
   output logic [DEF_W-1:0] def,
   output logic             bundle_valid,
   input  logic             bundle_ack,
   output logic             busy,
   output logic             overrun,
   output logic             par_err,
   output state_t           state_dbg
);

   localparam int FRAME_LEN = frame_len(DEF_W);
   localparam int CNT_W     = cnt_width(DEF_W);

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [FRAME_LEN-1:0] sr_data;
   logic [FRAME_LEN-1:0] commit_frame;
   logic                 sr_parity;
   logic                 shift_en;
   logic                 last_bit;

   // A load_start cycle never carries data: the first bit follows it.
   assign shift_en  = (state == ST_SHIFT) && sdi_valid && !load_start;
   assign last_bit  = (bit_cnt == CNT_W'(FRAME_LEN - 1));
   assign state_dbg = state;

`ifdef FOO_LOADER_PARITY_EN
   // Data is complete in the register by the time the parity bit arrives.
   assign commit_frame = sr_data;
`else
   // Commit on the last data bit itself, so splice that bit in directly.
   assign commit_frame = {sr_data[FRAME_LEN-2:0], sdi};
   logic unused_sr;
   assign unused_sr = ^{sr_data[FRAME_LEN-1], sr_parity};
`endif

   foo_loader_shreg #(
      .LEN (FRAME_LEN)
   ) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (load_start),
      .shift_en (shift_en),
      .sdi      (sdi),
      .data     (sr_data),
      .parity   (sr_parity)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         y            <= 1'b0;
         x            <= 1'b0;
         abcconst     <= '0;
         noconnect    <= '0;
         def          <= '0;
         bundle_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         par_err      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         par_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (load_start) begin
                  bit_cnt <= '0;
               end else if (sdi_valid) begin
                  if (last_bit) begin
`ifdef FOO_LOADER_PARITY_EN
                     state <= ST_PARITY;
`else
                     state        <= ST_HOLD;
                     busy         <= 1'b0;
                     bundle_valid <= 1'b1;
                     {y, x, abcconst, noconnect, def} <= commit_frame;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
`ifdef FOO_LOADER_PARITY_EN
            ST_PARITY: begin
               if (load_start) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
               end else if (sdi_valid) begin
                  busy <= 1'b0;
                  // Even parity: data XOR parity bit must be zero.
                  if (sr_parity ^ sdi) begin
                     par_err <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     state        <= ST_HOLD;
                     bundle_valid <= 1'b1;
                     {y, x, abcconst, noconnect, def} <= commit_frame;
                  end
               end
            end
`endif
            ST_HOLD: begin
               if (bundle_ack) begin
                  bundle_valid <= 1'b0;
                  if (load_start) begin
                     state   <= ST_SHIFT;
                     bit_cnt <= '0;
                     busy    <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (load_start) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_foo_port_loader.sv
// -----------------------------------------------------------------------------
// tb_foo_port_loader
// Self-checking bench for foo_port_loader. Frames are described as field
// records; the driver serialises them and pushes the expected bundle and
// commit latency, and a monitor pops and compares on every bundle_valid rise.
// Covers the FOO_LOADER_PARITY_EN build when that macro is defined.
// -----------------------------------------------------------------------------
module tb_foo_port_loader;
   import foo_loader_pkg::*;

   localparam int DEF_W = 32;
   localparam int FL    = frame_len(DEF_W);
`ifdef FOO_LOADER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             load_start, sdi, sdi_valid, bundle_ack;
   logic             y, x, bundle_valid, busy, overrun, par_err;
   logic [2:0]       abcconst;
   logic [3:0]       noconnect;
   logic [DEF_W-1:0] def;
   state_t           state_dbg;

   foo_port_loader #(.DEF_W(DEF_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .sdi          (sdi),
      .sdi_valid    (sdi_valid),
      .y            (y),
      .x            (x),
      .abcconst     (abcconst),
      .noconnect    (noconnect),
      .def          (def),
      .bundle_valid (bundle_valid),
      .bundle_ack   (bundle_ack),
      .busy         (busy),
      .overrun      (overrun),
      .par_err      (par_err),
      .state_dbg    (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [FL-1:0] exp_q[$];
   int            lat_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            since_ls = 0;
   int            ovr_cnt  = 0;
   int            perr_cnt = 0;
   logic          prev_v   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [FL-1:0] cur_bundle();
      return {y, x, abcconst, noconnect, def};
   endfunction

   // Edges since the last sampled load_start (commit latency reference).
   always @(posedge clk) begin
      if (load_start) since_ls <= 0;
      else            since_ls <= since_ls + 1;
   end

   always @(negedge clk) begin
      if (overrun) ovr_cnt++;
      if (par_err) perr_cnt++;
      if (bundle_valid && !prev_v) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_commit", 64'd1, 64'd0);
         end else begin
            logic [FL-1:0] e;
            int            l;
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk("commit_bundle", 64'(cur_bundle()), 64'(e));
            chk("commit_latency", 64'(since_ls), 64'(l));
         end
      end
      prev_v <= bundle_valid;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FL-1:0] pack(input logic yy, input logic xx, input logic [2:0] a,
                                          input logic [3:0] n, input logic [DEF_W-1:0] d);
      return {yy, xx, a, n, d};
   endfunction

   // n distinct stall positions in [lo, hi].
   function automatic logic [63:0] mk_mask(input int n, input int lo, input int hi);
      logic [63:0] m;
      int          p;
      m = '0;
      for (int k = 0; k < n; k++) begin
         do p = $urandom_range(hi, lo); while (m[p]);
         m[p] = 1'b1;
      end
      return m;
   endfunction

   // Opens a frame and sends nbits bits (data then parity bit); a complete,
   // good-parity frame pushes its expected bundle and latency.
   task automatic send(input logic [FL-1:0] frame, input int nbits,
                       input logic [63:0] stall_mask, input bit flip_par);
      int   lat;
      logic pb;
      lat = 0;
      pb  = (^frame) ^ flip_par;
      load_start = 1'b1;
      sdi_valid  = 1'b0;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (stall_mask[i]) begin
            sdi_valid = 1'b0;
            sdi       = 1'($urandom_range(1, 0));
            tick();
            lat++;
         end
         sdi_valid = 1'b1;
         if (i < FL) sdi = frame[FL-1-i];
         else        sdi = pb;
         lat++;
         if (i == FL + PAR - 1 && !flip_par) begin
            exp_q.push_back(frame);
            lat_q.push_back(lat);
         end
         tick();
      end
      sdi_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bundle_valid && n < 200) begin
         tick();
         n++;
      end
      chk("commit_timeout", 64'(bundle_valid), 64'd1);
   endtask

   task automatic ack_bundle();
      bundle_ack = 1'b1;
      tick();
      bundle_ack = 1'b0;
      chk("valid_drop", 64'(bundle_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic             y;
      logic             x;
      logic [2:0]       abc;
      logic [3:0]       nc;
      logic [DEF_W-1:0] def;
      int               stalls;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FL-1:0] saved, f;

      vecs[0] = '{1'b1, 1'b0, 3'h5, 4'hA, 32'h0000_0001, 0};
      vecs[1] = '{1'b1, 1'b0, 3'h5, 4'hA, 32'h0000_0001, 3};
      vecs[2] = '{1'b0, 1'b1, 3'h2, 4'h5, 32'hDEAD_BEEF, 0};
      vecs[3] = '{1'b1, 1'b1, 3'h7, 4'hF, 32'hFFFF_FFFF, 2};
      vecs[4] = '{1'b0, 1'b0, 3'h0, 4'h8, 32'h8000_0000, 1};

      rst_n      = 1'b0;
      load_start = 1'b0;
      sdi        = 1'b0;
      sdi_valid  = 1'b0;
      bundle_ack = 1'b0;
      repeat (3) tick();
      chk("rst_fields", 64'(cur_bundle()), 64'd0);
      chk("rst_valid", 64'(bundle_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pulses", 64'({overrun, par_err}), 64'd0);
      chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // Table: commit, field compare, ack.
      for (int v = 0; v < 5; v++) begin
         f = pack(vecs[v].y, vecs[v].x, vecs[v].abc, vecs[v].nc, vecs[v].def);
         send(f, FL + PAR, mk_mask(vecs[v].stalls, 12, 38), 1'b0);
         wait_valid();
         chk("vec_y", 64'(y), 64'(vecs[v].y));
         chk("vec_x", 64'(x), 64'(vecs[v].x));
         chk("vec_abc", 64'(abcconst), 64'(vecs[v].abc));
         chk("vec_nc", 64'(noconnect), 64'(vecs[v].nc));
         chk("vec_def", 64'(def), 64'(vecs[v].def));
         chk("hold_busy", 64'(busy), 64'd0);
         ack_bundle();
      end

      // Restart mid-frame: only the second frame commits, no overrun.
      send(pack(1'b1, 1'b1, 3'h3, 4'h3, 32'h1234_5678), 20, '0, 1'b0);
      chk("shift_busy", 64'(busy), 64'd1);
      send(pack(1'b0, 1'b1, 3'h6, 4'h9, 32'hDEAD_BEEF), FL + PAR, '0, 1'b0);
      wait_valid();
      chk("restart_no_overrun", 64'(ovr_cnt), 64'd0);

      // HOLD: load_start without ack is refused with an overrun pulse.
      saved = cur_bundle();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      chk("overrun_pulse", 64'(overrun), 64'd1);
      chk("overrun_hold_valid", 64'(bundle_valid), 64'd1);
      tick();
      chk("overrun_one_cycle", 64'(overrun), 64'd0);
      chk("overrun_bundle_kept", 64'(cur_bundle()), 64'(saved));
      chk("overrun_count", 64'(ovr_cnt), 64'd1);

      // HOLD: load_start with ack goes straight to SHIFT.
      load_start = 1'b1;
      bundle_ack = 1'b1;
      tick();
      load_start = 1'b0;
      bundle_ack = 1'b0;
      chk("ack_start_busy", 64'(busy), 64'd1);
      chk("ack_start_valid", 64'(bundle_valid), 64'd0);
      send(pack(1'b1, 1'b0, 3'h1, 4'h7, 32'h0F0F_A5A5), FL + PAR, '0, 1'b0);
      wait_valid();
      ack_bundle();

      // Asynchronous reset mid-frame, then a clean frame.
      send(pack(1'b1, 1'b1, 3'h7, 4'hF, 32'hFFFF_0000), 30, '0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_fields", 64'(cur_bundle()), 64'd0);
      chk("midrst_ctrl", 64'({bundle_valid, busy, overrun, par_err}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send(pack(1'b0, 1'b1, 3'h4, 4'hC, 32'hCAFE_F00D), FL + PAR, mk_mask(2, 5, 30), 1'b0);
      wait_valid();
      ack_bundle();

`ifdef FOO_LOADER_PARITY_EN
      // Good parity commits; flipped parity is discarded with par_err.
      send(pack(1'b1, 1'b0, 3'h2, 4'h6, 32'h0000_00FF), FL + PAR, '0, 1'b0);
      wait_valid();
      saved = cur_bundle();
      ack_bundle();
      send(pack(1'b0, 1'b0, 3'h5, 4'h1, 32'h7777_7777), FL + PAR, '0, 1'b1);
      chk("par_err_pulse", 64'(par_err), 64'd1);
      chk("par_err_no_valid", 64'(bundle_valid), 64'd0);
      tick();
      chk("par_err_one_cycle", 64'(par_err), 64'd0);
      chk("par_err_bundle_kept", 64'(cur_bundle()), 64'(saved));
      chk("par_err_count", 64'(perr_cnt), 64'd1);
      chk("par_err_idle", 64'(busy), 64'd0);
`else
      chk("par_err_tied", 64'(perr_cnt), 64'd0);
`endif

      repeat (3) tick();
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
